l1mmu_arbiter: RTL and testbench
================================

// Module: l1mmu_arbiter
// PURPOSE
//  Shares the single l1mmu refill/writeback port between the L1 iCache (read-only) and L1 dCache (read/write).
//  Sits between both L1 caches and l1mmu; replaces the combinational serve_ic steering in the top level.
//  Round-robin arbitration, registered request capture, one transaction in flight, done/data routed to the owner.
// PARAMETERS
//  ADDR_W          32    byte-address width of all request ports
//  LINE_W          256   cache-line width carried on read/write data
//  TIMEOUT_CYCLES  1024  watchdog limit, cycles in a SERVE state (used only with L1MMU_ARB_TIMEOUT_EN)
// PORTS
//  sys_clk        in   1       system clock; all state on rising edge
//  rst            in   1       synchronous reset, active-high
//  ic_req_read    in   1       iCache line read request; level, held until ic_read_done
//  ic_req_addr    in   ADDR_W  iCache line address
//  ic_read_done   out  1       1-cycle pulse: iCache read complete
//  ic_read_data   out  LINE_W  line data, valid only while ic_read_done=1
//  dc_req_read    in   1       dCache line read request; level, held until dc_read_done
//  dc_req_write   in   1       dCache line writeback request; level, held until dc_write_done
//  dc_req_addr    in   ADDR_W  dCache line address
//  dc_write_data  in   LINE_W  dCache writeback line
//  dc_read_done   out  1       1-cycle pulse: dCache read complete
//  dc_write_done  out  1       1-cycle pulse: dCache write complete
//  dc_read_data   out  LINE_W  line data, valid only while dc_read_done=1
//  mmu_req_read   out  1       read request to l1mmu
//  mmu_req_write  out  1       write request to l1mmu
//  mmu_req_addr   out  ADDR_W  registered address to l1mmu
//  mmu_write_data out  LINE_W  registered write line to l1mmu
//  mmu_read_done  in   1       l1mmu read-complete pulse
//  mmu_write_done in   1       l1mmu write-complete pulse
//  mmu_read_data  in   LINE_W  l1mmu read line
//  arb_busy       out  1       1 while in SERVE_IC or SERVE_DC
//  timeout_err    out  1       sticky watchdog flag (present only with L1MMU_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state=IDLE, last_ic=0 (iCache wins first tie), all outputs 0, captured addr/data 0.
//  FSM IDLE -> SERVE_IC | SERVE_DC -> IDLE. Candidates: ic=ic_req_read; dc=dc_req_read|dc_req_write.
//  IDLE, one candidate: grant it. Both: grant the one NOT last served (last_ic=1 -> dc). None: stay.
//  Grant edge: capture addr, write data and kind (dc_req_write has precedence over dc_req_read if both high); update last_ic.
//  SERVE_*: mmu_req_read/mmu_req_write driven from registered kind; exactly one high. IDLE: both 0.
//  Latency: request high in IDLE at cycle N -> mmu_req_* high at N+1; requests ignored outside IDLE.
//  Completion: matching done pulse (read_done for read, write_done for write) forwarded combinationally to owner's
//   done in the same cycle; FSM returns to IDLE next edge, mmu_req_* low that cycle. Non-matching done ignored.
//  mmu_read_data drives ic_read_data and dc_read_data unconditionally; done pulses qualify.
//  Done pulses from l1mmu in IDLE are ignored, never forwarded. Min 1 IDLE cycle between transactions.
//  Requester dropping its request mid-transaction does not abort; transaction completes, done still pulsed.
//  Reset mid-transaction: FSM to IDLE immediately, no done forwarded; l1mmu is reset by the same rst.
// CONFIGURATION
//  L1MMU_ARB_TIMEOUT_EN defined: 32-bit wait counter clears on grant, increments each SERVE cycle; reaching
//   TIMEOUT_CYCLES forces IDLE, pulses owner's matching done (data undefined), sets timeout_err until rst.
//  Undefined: no counter, no timeout_err port; SERVE waits for done indefinitely.
// STRUCTURE
//  Package l1mmu_arb_pkg: state enum {IDLE,SERVE_IC,SERVE_DC}, req-kind enum {RD,WR}, default ADDR_W/LINE_W.
//  Sub-module l1mmu_arb_rr_pick: 2-way round-robin picker (ic_cand, dc_cand, last_ic -> pick_ic, pick_dc).
// TESTING
//  1. ic_req_read alone, addr 0x0000_1000; mmu_read_done 5 cycles later with data 0xA5..A5 -> mmu_req_addr=0x1000
//     next cycle, ic_read_done 1-cycle pulse with 0xA5..A5, dc_*_done stay 0.
//  2. dc_req_write addr 0x0040_0020, data 0x1234.. -> mmu_req_write=1, mmu_write_data=0x1234..; mmu_write_done ->
//     dc_write_done pulse; an mmu_read_done in same transaction is ignored.
//  3. ic and dc request simultaneously after reset, then again after completion -> ic served first, dc second,
//     then on next tie ic again (alternation); one IDLE cycle between grants.
//  4. dc_req_read and dc_req_write both high -> write issued only; rst asserted during SERVE -> mmu_req_* 0 next
//     cycle, arb_busy=0, no done pulse.
//  5. Spurious mmu_read_done in IDLE -> no done forwarded, state stays IDLE.
//  6. L1MMU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no mmu done -> after 8 SERVE cycles owner done pulses,
//     timeout_err=1 and stays 1 until rst.

Source files
------------

// File: rtl/l1mmu_arb_pkg.sv
// l1mmu_arb_pkg: shared types and default widths for the l1mmu arbiter.
// The optional watchdog in l1mmu_arbiter is enabled by L1MMU_ARB_TIMEOUT_EN.
package l1mmu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IC = 2'd1,
    SERVE_DC = 2'd2
  } arb_state_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } req_kind_e;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_LINE_W         = 256;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/l1mmu_arb_rr_pick.sv
// l1mmu_arb_rr_pick: 2-way round-robin picker. On a tie the requester that
// was not served last wins; a lone candidate always wins.
module l1mmu_arb_rr_pick (
  input  logic ic_cand,
  input  logic dc_cand,
  input  logic last_ic,
  output logic pick_ic,
  output logic pick_dc
);

  // Tie goes to dCache only when iCache was the previous owner.
  always_comb begin
    pick_ic = ic_cand && (!dc_cand || !last_ic);
    pick_dc = dc_cand && (!ic_cand ||  last_ic);
  end

endmodule

// File: rtl/l1mmu_arbiter.sv
// l1mmu_arbiter: shares the single l1mmu refill/writeback port between the
// iCache (read-only) and dCache (read/write). One transaction in flight,
// round-robin on ties, registered request capture, done routed to the owner.
// Define L1MMU_ARB_TIMEOUT_EN to add the SERVE watchdog and timeout_err port.
module l1mmu_arbiter
  import l1mmu_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
`ifdef L1MMU_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`endif
  parameter int LINE_W         = DEF_LINE_W
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              ic_req_read,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_read_done,
  output logic [LINE_W-1:0] ic_read_data,
  input  logic              dc_req_read,
  input  logic              dc_req_write,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_read_done,
  output logic              dc_write_done,
  output logic [LINE_W-1:0] dc_read_data,
  output logic              mmu_req_read,
  output logic              mmu_req_write,
  output logic [ADDR_W-1:0] mmu_req_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_read_done,
  input  logic              mmu_write_done,
  input  logic [LINE_W-1:0] mmu_read_data,
`ifdef L1MMU_ARB_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic              arb_busy
);

  arb_state_e        state_q, state_d;
  req_kind_e         kind_q, kind_d;
  logic              last_ic_q, last_ic_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic pick_ic, pick_dc;
  logic serving;
  logic done_hit;
  logic timeout_hit;

  l1mmu_arb_rr_pick u_rr_pick (
    .ic_cand (ic_req_read),
    .dc_cand (dc_req_read | dc_req_write),
    .last_ic (last_ic_q),
    .pick_ic (pick_ic),
    .pick_dc (pick_dc)
  );

  assign serving = (state_q == SERVE_IC) || (state_q == SERVE_DC);

`ifdef L1MMU_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_err_q, timeout_err_d;

  // Watchdog: counter restarts on every grant and fires on the last allowed SERVE cycle.
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    timeout_hit   = serving && (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    if (state_q == IDLE) begin
      wait_cnt_d = 32'd0;
    end else begin
      wait_cnt_d = wait_cnt_q + 32'd1;
    end
    if (timeout_hit) begin
      timeout_err_d = 1'b1;
    end
  end

  // Watchdog registers; the error flag is sticky until reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wait_cnt_q    <= 32'd0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // A transaction ends on the done pulse matching its kind (or on a watchdog expiry).
  assign done_hit = serving &&
                    (((kind_q == RD) && mmu_read_done) ||
                     ((kind_q == WR) && mmu_write_done) ||
                     timeout_hit);

  // Next-state: grant and capture in IDLE, wait for completion while serving.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    last_ic_d = last_ic_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (pick_ic) begin
          state_d   = SERVE_IC;
          kind_d    = RD;
          addr_d    = ic_req_addr;
          last_ic_d = 1'b1;
        end else if (pick_dc) begin
          state_d   = SERVE_DC;
          kind_d    = dc_req_write ? WR : RD;
          addr_d    = dc_req_addr;
          wdata_d   = dc_write_data;
          last_ic_d = 1'b0;
        end
      end
      SERVE_IC, SERVE_DC: begin
        if (done_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      kind_q    <= RD;
      last_ic_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      last_ic_q <= last_ic_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign mmu_req_read   = serving && (kind_q == RD);
  assign mmu_req_write  = serving && (kind_q == WR);
  assign mmu_req_addr   = addr_q;
  assign mmu_write_data = wdata_q;
  assign arb_busy       = serving;

  // Completion is suppressed while rst is high so a reset never leaks a done.
  assign ic_read_done  = !rst && done_hit && (state_q == SERVE_IC);
  assign dc_read_done  = !rst && done_hit && (state_q == SERVE_DC) && (kind_q == RD);
  assign dc_write_done = !rst && done_hit && (state_q == SERVE_DC) && (kind_q == WR);

  assign ic_read_data = mmu_read_data;
  assign dc_read_data = mmu_read_data;

endmodule

// File: tb/tb_l1mmu_arbiter.sv
// tb_l1mmu_arbiter: directed self-checking bench for l1mmu_arbiter.
// Inputs change 1 ns after the rising edge; outputs are checked mid-cycle.
// The watchdog scenario is included when L1MMU_ARB_TIMEOUT_EN is defined.
module tb_l1mmu_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic              ic_req_read;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_read_done;
  logic [LINE_W-1:0] ic_read_data;
  logic              dc_req_read;
  logic              dc_req_write;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [LINE_W-1:0] dc_write_data;
  logic              dc_read_done;
  logic              dc_write_done;
  logic [LINE_W-1:0] dc_read_data;
  logic              mmu_req_read;
  logic              mmu_req_write;
  logic [ADDR_W-1:0] mmu_req_addr;
  logic [LINE_W-1:0] mmu_write_data;
  logic              mmu_read_done;
  logic              mmu_write_done;
  logic [LINE_W-1:0] mmu_read_data;
  logic              arb_busy;
`ifdef L1MMU_ARB_TIMEOUT_EN
  logic              timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [LINE_W-1:0] DATA_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] DATA_WR = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] DATA_5A = {32{8'h5A}};

  always #5 sys_clk = ~sys_clk;

  l1mmu_arbiter #(
    .ADDR_W         (ADDR_W),
`ifdef L1MMU_ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES (8),
`endif
    .LINE_W         (LINE_W)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .ic_req_read    (ic_req_read),
    .ic_req_addr    (ic_req_addr),
    .ic_read_done   (ic_read_done),
    .ic_read_data   (ic_read_data),
    .dc_req_read    (dc_req_read),
    .dc_req_write   (dc_req_write),
    .dc_req_addr    (dc_req_addr),
    .dc_write_data  (dc_write_data),
    .dc_read_done   (dc_read_done),
    .dc_write_done  (dc_write_done),
    .dc_read_data   (dc_read_data),
    .mmu_req_read   (mmu_req_read),
    .mmu_req_write  (mmu_req_write),
    .mmu_req_addr   (mmu_req_addr),
    .mmu_write_data (mmu_write_data),
    .mmu_read_done  (mmu_read_done),
    .mmu_write_done (mmu_write_done),
    .mmu_read_data  (mmu_read_data),
`ifdef L1MMU_ARB_TIMEOUT_EN
    .timeout_err    (timeout_err),
`endif
    .arb_busy       (arb_busy)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dones(input string tag, input logic ic_rd, input logic dc_rd, input logic dc_wr);
    check({tag, ".ic_read_done"}, LINE_W'(ic_read_done), LINE_W'(ic_rd));
    check({tag, ".dc_read_done"}, LINE_W'(dc_read_done), LINE_W'(dc_rd));
    check({tag, ".dc_write_done"}, LINE_W'(dc_write_done), LINE_W'(dc_wr));
  endtask

  task automatic check_req(input string tag, input logic busy, input logic rd, input logic wr);
    check({tag, ".arb_busy"}, LINE_W'(arb_busy), LINE_W'(busy));
    check({tag, ".mmu_req_read"}, LINE_W'(mmu_req_read), LINE_W'(rd));
    check({tag, ".mmu_req_write"}, LINE_W'(mmu_req_write), LINE_W'(wr));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    rst = 1'b1;
    ic_req_read = 1'b0; ic_req_addr = '0;
    dc_req_read = 1'b0; dc_req_write = 1'b0; dc_req_addr = '0; dc_write_data = '0;
    mmu_read_done = 1'b0; mmu_write_done = 1'b0; mmu_read_data = '0;
    tick(); tick();
    rst = 1'b0;
    #4;
    check_req("reset", 1'b0, 1'b0, 1'b0);
    check("reset.addr", LINE_W'(mmu_req_addr), '0);
    check("reset.wdata", mmu_write_data, '0);
    check_dones("reset", 1'b0, 1'b0, 1'b0);

    // iCache read alone; completes 5 cycles after the request.
    tick();
    ic_req_read = 1'b1; ic_req_addr = 32'h0000_1000;
    #4;
    check_req("ic.req_cycle", 1'b0, 1'b0, 1'b0);
    tick();
    #4;
    check_req("ic.serve", 1'b1, 1'b1, 1'b0);
    check("ic.addr", LINE_W'(mmu_req_addr), LINE_W'(32'h0000_1000));
    tick(); tick(); tick();
    #4;
    check_req("ic.wait", 1'b1, 1'b1, 1'b0);
    check_dones("ic.wait", 1'b0, 1'b0, 1'b0);
    tick();
    mmu_read_done = 1'b1; mmu_read_data = DATA_A5; ic_req_read = 1'b0;
    #4;
    check_dones("ic.done", 1'b1, 1'b0, 1'b0);
    check("ic.data", ic_read_data, DATA_A5);
    tick();
    mmu_read_done = 1'b0;
    #4;
    check_req("ic.after", 1'b0, 1'b0, 1'b0);
    check_dones("ic.after", 1'b0, 1'b0, 1'b0);

    // dCache writeback; a read_done during it is ignored.
    tick();
    dc_req_write = 1'b1; dc_req_addr = 32'h0040_0020; dc_write_data = DATA_WR;
    tick();
    #4;
    check_req("dcw.serve", 1'b1, 1'b0, 1'b1);
    check("dcw.addr", LINE_W'(mmu_req_addr), LINE_W'(32'h0040_0020));
    check("dcw.wdata", mmu_write_data, DATA_WR);
    tick();
    mmu_read_done = 1'b1;
    #4;
    check_dones("dcw.wrong_done", 1'b0, 1'b0, 1'b0);
    tick();
    mmu_read_done = 1'b0; mmu_write_done = 1'b1; dc_req_write = 1'b0;
    #4;
    check_req("dcw.still", 1'b1, 1'b0, 1'b1);
    check_dones("dcw.done", 1'b0, 1'b0, 1'b1);
    tick();
    mmu_write_done = 1'b0;
    #4;
    check_req("dcw.after", 1'b0, 1'b0, 1'b0);

    // Spurious done while idle.
    mmu_read_done = 1'b1; mmu_write_done = 1'b1;
    #1;
    check_dones("spurious", 1'b0, 1'b0, 1'b0);
    tick();
    mmu_read_done = 1'b0; mmu_write_done = 1'b0;
    #4;
    check_req("spurious.idle", 1'b0, 1'b0, 1'b0);

    // Simultaneous requests after reset: ic, dc, then ic again.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ic_req_read = 1'b1; ic_req_addr = 32'h0000_0100;
    dc_req_read = 1'b1; dc_req_addr = 32'h0000_0200;
    tick();
    #4;
    check_req("rr1.serve", 1'b1, 1'b1, 1'b0);
    check("rr1.addr", LINE_W'(mmu_req_addr), LINE_W'(32'h0000_0100));
    tick();
    mmu_read_done = 1'b1; mmu_read_data = DATA_5A;
    #4;
    check_dones("rr1.done", 1'b1, 1'b0, 1'b0);
    tick();
    mmu_read_done = 1'b0;
    #4;
    check_req("rr1.gap", 1'b0, 1'b0, 1'b0);
    tick();
    #4;
    check_req("rr2.serve", 1'b1, 1'b1, 1'b0);
    check("rr2.addr", LINE_W'(mmu_req_addr), LINE_W'(32'h0000_0200));
    tick();
    mmu_read_done = 1'b1;
    #4;
    check_dones("rr2.done", 1'b0, 1'b1, 1'b0);
    check("rr2.data", dc_read_data, DATA_5A);
    tick();
    mmu_read_done = 1'b0;
    #4;
    check_req("rr2.gap", 1'b0, 1'b0, 1'b0);
    tick();
    #4;
    check("rr3.addr", LINE_W'(mmu_req_addr), LINE_W'(32'h0000_0100));
    tick();
    mmu_read_done = 1'b1; ic_req_read = 1'b0; dc_req_read = 1'b0;
    #4;
    check_dones("rr3.done", 1'b1, 1'b0, 1'b0);
    tick();
    mmu_read_done = 1'b0;

    // Read and write both high: write wins; reset aborts without a done.
    tick();
    dc_req_read = 1'b1; dc_req_write = 1'b1; dc_req_addr = 32'h0000_0300;
    dc_write_data = DATA_A5;
    tick();
    dc_req_read = 1'b0; dc_req_write = 1'b0;
    #4;
    check_req("both.serve", 1'b1, 1'b0, 1'b1);
    tick();
    rst = 1'b1; mmu_write_done = 1'b1;
    #4;
    check_dones("rst.no_done", 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0; mmu_write_done = 1'b0;
    #4;
    check_req("rst.after", 1'b0, 1'b0, 1'b0);
    check("rst.addr", LINE_W'(mmu_req_addr), '0);

`ifdef L1MMU_ARB_TIMEOUT_EN
    // Watchdog: no done for 8 SERVE cycles.
    check("to.err_init", LINE_W'(timeout_err), '0);
    tick();
    ic_req_read = 1'b1; ic_req_addr = 32'h0000_0400;
    tick();
    ic_req_read = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #4;
    check_req("to.cycle7", 1'b1, 1'b1, 1'b0);
    check_dones("to.cycle7", 1'b0, 1'b0, 1'b0);
    tick();
    #4;
    check_dones("to.cycle8", 1'b1, 1'b0, 1'b0);
    check("to.err_pre", LINE_W'(timeout_err), '0);
    tick();
    #4;
    check_req("to.idle", 1'b0, 1'b0, 1'b0);
    check("to.err_set", LINE_W'(timeout_err), LINE_W'(1'b1));
    tick(); tick(); tick();
    #4;
    check("to.err_sticky", LINE_W'(timeout_err), LINE_W'(1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #4;
    check("to.err_clear", LINE_W'(timeout_err), '0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
